// File: rtl/seq_loop_mon_pkg.sv
// Shared types and helpers for the HLS sequential-loop monitor.
package seq_loop_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    HALT = 2'd2
  } mon_state_e;

  localparam int unsigned STALL_LIMIT_DEFAULT = 1000000;
  localparam int unsigned SAT_MAX_W           = 64;

  // Increment that sticks at the all-ones value of a w-bit counter (w <= SAT_MAX_W).
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                   input int unsigned          w);
    logic [SAT_MAX_W-1:0] max_v;
    max_v = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
    return (v >= max_v) ? v : v + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/seq_state_set_match.sv
// Membership test of a query state against a masked, packed set of FSM states.
module seq_state_set_match
  import seq_loop_mon_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned FSM_WIDTH = 2
) (
  input  logic [N-1:0]           valid_i,
  input  logic [N*FSM_WIDTH-1:0] states_i,
  input  logic [FSM_WIDTH-1:0]   query_i,
  output logic                   hit_c
);

  always_comb begin
    hit_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (valid_i[i] && (states_i[i*FSM_WIDTH +: FSM_WIDTH] == query_i)) hit_c = 1'b1;
    end
  end

endmodule

// File: rtl/seq_loop_monitor.sv
// Cycle-level entry/iteration/exit monitor for one HLS sequential loop.
// Optional min/max iteration tracking is enabled by defining SEQ_LOOP_MON_MINMAX_EN.
module seq_loop_monitor
  import seq_loop_mon_pkg::*;
#(
  parameter int unsigned FSM_WIDTH   = 2,
  parameter int unsigned N_PRE       = 4,
  parameter int unsigned N_QUIT      = 16,
  parameter int unsigned N_ITER_END  = 4,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [FSM_WIDTH-1:0]            cur_state,
  input  logic [N_PRE-1:0]                pre_valid,
  input  logic [N_PRE*FSM_WIDTH-1:0]      pre_states,
  input  logic [N_QUIT-1:0]               quit_valid,
  input  logic [N_QUIT*FSM_WIDTH-1:0]     quit_states,
  input  logic [N_ITER_END-1:0]           iter_end_valid,
  input  logic [N_ITER_END*FSM_WIDTH-1:0] iter_end_states,
  input  logic [FSM_WIDTH-1:0]            iter_start_state,
  input  logic [FSM_WIDTH-1:0]            loop_quit_state,
  input  logic                            one_state_loop,
  input  logic                            one_state_block,
  input  logic                            finish,
  output logic                            in_loop,
  output logic                            iter_pulse,
  output logic                            exit_pulse,
  output logic [CNT_WIDTH-1:0]            iter_count,
  output logic [CNT_WIDTH-1:0]            invoc_count,
  output logic                            stall_err,
`ifdef SEQ_LOOP_MON_MINMAX_EN
  output logic [CNT_WIDTH-1:0]            min_iters,
  output logic [CNT_WIDTH-1:0]            max_iters,
`endif
  output logic                            protocol_err
);

  logic [FSM_WIDTH-1:0] prev_state_q;
  mon_state_e           state_q, state_d;
  logic                 in_loop_q, in_loop_d;
  logic                 iter_pulse_q, iter_pulse_d;
  logic                 exit_pulse_q, exit_pulse_d;
  logic [CNT_WIDTH-1:0] iter_count_q, iter_count_d;
  logic [CNT_WIDTH-1:0] invoc_count_q, invoc_count_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                 stall_err_q, stall_err_d;
  logic                 protocol_err_q, protocol_err_d;
`ifdef SEQ_LOOP_MON_MINMAX_EN
  logic [CNT_WIDTH-1:0] min_iters_q, min_iters_d;
  logic [CNT_WIDTH-1:0] max_iters_q, max_iters_d;
`endif

  logic                 pre_hit_c, quit_hit_c, iter_end_hit_c;
  logic                 entry_c, iter_c, exit_c;
  logic [CNT_WIDTH-1:0] iter_inc_c, invoc_inc_c, stall_inc_c;

  seq_state_set_match #(.N(N_PRE), .FSM_WIDTH(FSM_WIDTH)) u_pre_match (
    .valid_i(pre_valid), .states_i(pre_states), .query_i(prev_state_q), .hit_c(pre_hit_c)
  );

  seq_state_set_match #(.N(N_QUIT), .FSM_WIDTH(FSM_WIDTH)) u_quit_match (
    .valid_i(quit_valid), .states_i(quit_states), .query_i(prev_state_q), .hit_c(quit_hit_c)
  );

  seq_state_set_match #(.N(N_ITER_END), .FSM_WIDTH(FSM_WIDTH)) u_iter_end_match (
    .valid_i(iter_end_valid), .states_i(iter_end_states), .query_i(prev_state_q),
    .hit_c(iter_end_hit_c)
  );

  // Transition events seen on the (prev_state, cur_state) pair.
  assign entry_c = pre_hit_c && (cur_state == iter_start_state);
  assign iter_c  = (cur_state == iter_start_state) &&
                   (one_state_loop ? (prev_state_q == iter_start_state) : iter_end_hit_c);
  assign exit_c  = quit_hit_c && (cur_state == loop_quit_state);

  assign iter_inc_c  = CNT_WIDTH'(sat_inc(SAT_MAX_W'(iter_count_q), CNT_WIDTH));
  assign invoc_inc_c = CNT_WIDTH'(sat_inc(SAT_MAX_W'(invoc_count_q), CNT_WIDTH));
  assign stall_inc_c = CNT_WIDTH'(sat_inc(SAT_MAX_W'(stall_cnt_q), CNT_WIDTH));

  always_comb begin
    state_d        = state_q;
    iter_pulse_d   = 1'b0;
    exit_pulse_d   = 1'b0;
    iter_count_d   = iter_count_q;
    invoc_count_d  = invoc_count_q;
    stall_cnt_d    = stall_cnt_q;
    stall_err_d    = stall_err_q;
    protocol_err_d = protocol_err_q;
`ifdef SEQ_LOOP_MON_MINMAX_EN
    min_iters_d    = min_iters_q;
    max_iters_d    = max_iters_q;
`endif
    if (finish) begin
      state_d = HALT;
      if (state_q == LOOP) protocol_err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (entry_c) begin
            state_d      = LOOP;
            iter_count_d = '0;
            stall_cnt_d  = '0;
          end
        end
        LOOP: begin
          stall_cnt_d = stall_inc_c;
          if (entry_c) protocol_err_d = 1'b1;
          // Exit takes priority; the last body pass is counted exactly once.
          if (exit_c) begin
            state_d       = IDLE;
            exit_pulse_d  = 1'b1;
            invoc_count_d = invoc_inc_c;
            if (!one_state_block) begin
              iter_count_d = iter_inc_c;
`ifdef SEQ_LOOP_MON_MINMAX_EN
              if (iter_inc_c < min_iters_q) min_iters_d = iter_inc_c;
              if (iter_inc_c > max_iters_q) max_iters_d = iter_inc_c;
`endif
            end
          end else if (iter_c) begin
            iter_pulse_d = 1'b1;
            stall_cnt_d  = '0;
            if (!one_state_block) iter_count_d = iter_inc_c;
          end
          if (stall_cnt_d == CNT_WIDTH'(STALL_LIMIT)) stall_err_d = 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
    in_loop_d = (state_d == LOOP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_state_q   <= '0;
      state_q        <= IDLE;
      in_loop_q      <= 1'b0;
      iter_pulse_q   <= 1'b0;
      exit_pulse_q   <= 1'b0;
      iter_count_q   <= '0;
      invoc_count_q  <= '0;
      stall_cnt_q    <= '0;
      stall_err_q    <= 1'b0;
      protocol_err_q <= 1'b0;
`ifdef SEQ_LOOP_MON_MINMAX_EN
      min_iters_q    <= '1;
      max_iters_q    <= '0;
`endif
    end else begin
      prev_state_q   <= cur_state;
      state_q        <= state_d;
      in_loop_q      <= in_loop_d;
      iter_pulse_q   <= iter_pulse_d;
      exit_pulse_q   <= exit_pulse_d;
      iter_count_q   <= iter_count_d;
      invoc_count_q  <= invoc_count_d;
      stall_cnt_q    <= stall_cnt_d;
      stall_err_q    <= stall_err_d;
      protocol_err_q <= protocol_err_d;
`ifdef SEQ_LOOP_MON_MINMAX_EN
      min_iters_q    <= min_iters_d;
      max_iters_q    <= max_iters_d;
`endif
    end
  end

  assign in_loop      = in_loop_q;
  assign iter_pulse   = iter_pulse_q;
  assign exit_pulse   = exit_pulse_q;
  assign iter_count   = iter_count_q;
  assign invoc_count  = invoc_count_q;
  assign stall_err    = stall_err_q;
  assign protocol_err = protocol_err_q;
`ifdef SEQ_LOOP_MON_MINMAX_EN
  assign min_iters    = min_iters_q;
  assign max_iters    = max_iters_q;
`endif

endmodule

// File: tb/tb_seq_loop_monitor.sv
// Directed self-checking bench for seq_loop_monitor (4-bit states, 8-bit counters, stall limit 8).
module tb_seq_loop_monitor;

  localparam int unsigned FW = 4;
  localparam int unsigned NP = 2;
  localparam int unsigned NQ = 2;
  localparam int unsigned NI = 2;
  localparam int unsigned CW = 8;
  localparam int unsigned SL = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [FW-1:0]     cur_state;
  logic [NP-1:0]     pre_valid;
  logic [NP*FW-1:0]  pre_states;
  logic [NQ-1:0]     quit_valid;
  logic [NQ*FW-1:0]  quit_states;
  logic [NI-1:0]     iter_end_valid;
  logic [NI*FW-1:0]  iter_end_states;
  logic [FW-1:0]     iter_start_state;
  logic [FW-1:0]     loop_quit_state;
  logic              one_state_loop;
  logic              one_state_block;
  logic              finish;
  logic              in_loop;
  logic              iter_pulse;
  logic              exit_pulse;
  logic [CW-1:0]     iter_count;
  logic [CW-1:0]     invoc_count;
  logic              stall_err;
  logic              protocol_err;
`ifdef SEQ_LOOP_MON_MINMAX_EN
  logic [CW-1:0]     min_iters;
  logic [CW-1:0]     max_iters;
`endif

  seq_loop_monitor #(
    .FSM_WIDTH(FW), .N_PRE(NP), .N_QUIT(NQ), .N_ITER_END(NI), .CNT_WIDTH(CW), .STALL_LIMIT(SL)
  ) dut (
    .clock(clock), .reset(reset), .cur_state(cur_state),
    .pre_valid(pre_valid), .pre_states(pre_states),
    .quit_valid(quit_valid), .quit_states(quit_states),
    .iter_end_valid(iter_end_valid), .iter_end_states(iter_end_states),
    .iter_start_state(iter_start_state), .loop_quit_state(loop_quit_state),
    .one_state_loop(one_state_loop), .one_state_block(one_state_block), .finish(finish),
    .in_loop(in_loop), .iter_pulse(iter_pulse), .exit_pulse(exit_pulse),
    .iter_count(iter_count), .invoc_count(invoc_count), .stall_err(stall_err),
`ifdef SEQ_LOOP_MON_MINMAX_EN
    .min_iters(min_iters), .max_iters(max_iters),
`endif
    .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int n_iter_p = 0;
  int n_exit_p = 0;
  int pi, pe;

  // Pulse tallies sampled mid-cycle.
  always @(negedge clock) begin
    if (iter_pulse) n_iter_p++;
    if (exit_pulse) n_exit_p++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [FW-1:0] s);
    cur_state = s;
    @(posedge clock);
    #1;
  endtask

  task automatic iterate(input int n);
    for (int i = 0; i < n; i++) begin
      step(4'd3);
      step(4'd2);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(4'd0);
    step(4'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_in_loop"},    32'(in_loop),      32'd0);
    check_eq({tag, "_iter_pulse"}, 32'(iter_pulse),   32'd0);
    check_eq({tag, "_exit_pulse"}, 32'(exit_pulse),   32'd0);
    check_eq({tag, "_iter_count"}, 32'(iter_count),   32'd0);
    check_eq({tag, "_invoc"},      32'(invoc_count),  32'd0);
    check_eq({tag, "_stall_err"},  32'(stall_err),    32'd0);
    check_eq({tag, "_proto_err"},  32'(protocol_err), 32'd0);
  endtask

  initial begin
    reset            = 1'b1;
    finish           = 1'b0;
    one_state_loop   = 1'b0;
    one_state_block  = 1'b0;
    pre_valid        = 2'b01;
    pre_states       = {4'd0, 4'd1};
    quit_valid       = 2'b01;
    quit_states      = {4'd0, 4'd3};
    iter_end_valid   = 2'b01;
    iter_end_states  = {4'd0, 4'd3};
    iter_start_state = 4'd2;
    loop_quit_state  = 4'd5;
    cur_state        = 4'd0;

    do_reset();
    check_all_zero("rst");
    reset = 1'b0;

    // Basic loop: 1,2,3,2,3,2,3,5
    pi = n_iter_p; pe = n_exit_p;
    step(4'd1); step(4'd2);
    check_eq("t1_enter_in_loop", 32'(in_loop), 32'd1);
    check_eq("t1_enter_count", 32'(iter_count), 32'd0);
    step(4'd3); step(4'd2);
    check_eq("t1_iter_pulse", 32'(iter_pulse), 32'd1);
    check_eq("t1_iter_count1", 32'(iter_count), 32'd1);
    step(4'd3); step(4'd2); step(4'd3); step(4'd5);
    check_eq("t1_exit_pulse", 32'(exit_pulse), 32'd1);
    check_eq("t1_exit_in_loop", 32'(in_loop), 32'd0);
    check_eq("t1_iter_count", 32'(iter_count), 32'd3);
    check_eq("t1_invoc", 32'(invoc_count), 32'd1);
    step(4'd0);
    check_eq("t1_exit_one_cycle", 32'(exit_pulse), 32'd0);
    check_eq("t1_n_iter_pulses", 32'(n_iter_p - pi), 32'd2);
    check_eq("t1_n_exit_pulses", 32'(n_exit_p - pe), 32'd1);

    // Exit transition while idle is ignored
    step(4'd3); step(4'd5);
    check_eq("idle_exit_pulse", 32'(exit_pulse), 32'd0);
    check_eq("idle_exit_invoc", 32'(invoc_count), 32'd1);

    // Single-state loop body: 1,2,2,2,2,5 with quit={2}
    one_state_loop = 1'b1;
    quit_states    = {4'd0, 4'd2};
    step(4'd1); step(4'd2); step(4'd2); step(4'd2); step(4'd2);
    check_eq("t2_iter_count_mid", 32'(iter_count), 32'd3);
    step(4'd5);
    check_eq("t2_exit_pulse", 32'(exit_pulse), 32'd1);
    check_eq("t2_iter_count", 32'(iter_count), 32'd4);
    check_eq("t2_invoc", 32'(invoc_count), 32'd2);
    one_state_loop = 1'b0;
    quit_states    = {4'd0, 4'd3};
    step(4'd0);

    // Iteration counter saturation at 255
    step(4'd1); step(4'd2);
    iterate(300);
    check_eq("sat_iter_mid", 32'(iter_count), 32'd255);
    step(4'd3); step(4'd5);
    check_eq("sat_iter_exit", 32'(iter_count), 32'd255);
    check_eq("sat_invoc", 32'(invoc_count), 32'd3);
    check_eq("sat_no_stall", 32'(stall_err), 32'd0);

    // one_state_block: pulses still fire but iterations are not counted
    one_state_block = 1'b1;
    pi = n_iter_p;
    step(4'd1); step(4'd2); step(4'd3); step(4'd2); step(4'd3); step(4'd5);
    check_eq("osb_iter_count", 32'(iter_count), 32'd0);
    check_eq("osb_invoc", 32'(invoc_count), 32'd4);
    step(4'd0);
    check_eq("osb_n_iter_pulses", 32'(n_iter_p - pi), 32'd1);
    one_state_block = 1'b0;

    // Re-entry while looping flags a protocol error
    step(4'd1); step(4'd2); step(4'd1); step(4'd2);
    check_eq("reentry_proto_err", 32'(protocol_err), 32'd1);
    check_eq("reentry_in_loop", 32'(in_loop), 32'd1);
    iterate(2);
    check_eq("reentry_iter_count", 32'(iter_count), 32'd2);

    // Reset mid-loop
    pe = n_exit_p;
    do_reset();
    check_all_zero("mid_rst");
    reset = 1'b0;
    step(4'd0);
    check_eq("mid_rst_no_exit", 32'(n_exit_p - pe), 32'd0);

    // Disabled quit entry blocks the exit
    quit_valid = 2'b00;
    step(4'd1); step(4'd2); step(4'd3); step(4'd5);
    check_eq("dis_quit_in_loop", 32'(in_loop), 32'd1);
    check_eq("dis_quit_no_exit", 32'(exit_pulse), 32'd0);
    quit_valid = 2'b01;
    step(4'd3); step(4'd5);
    check_eq("en_quit_exit", 32'(exit_pulse), 32'd1);
    check_eq("en_quit_invoc", 32'(invoc_count), 32'd1);
    check_eq("en_quit_iter_count", 32'(iter_count), 32'd1);

    // Stall: 8 LOOP cycles with no iteration boundary
    step(4'd0); step(4'd1); step(4'd2);
    for (int i = 0; i < 7; i++) step(4'd3);
    check_eq("stall_before_limit", 32'(stall_err), 32'd0);
    step(4'd3);
    check_eq("stall_at_limit", 32'(stall_err), 32'd1);
    step(4'd5);
    check_eq("stall_exit_pulse", 32'(exit_pulse), 32'd1);
    check_eq("stall_sticky", 32'(stall_err), 32'd1);

    // finish mid-loop
    step(4'd0); step(4'd1); step(4'd2);
    check_eq("fin_pre_in_loop", 32'(in_loop), 32'd1);
    check_eq("fin_pre_proto", 32'(protocol_err), 32'd0);
    finish = 1'b1;
    step(4'd3);
    finish = 1'b0;
    check_eq("fin_in_loop", 32'(in_loop), 32'd0);
    check_eq("fin_proto_err", 32'(protocol_err), 32'd1);
    pi = n_iter_p; pe = n_exit_p;
    step(4'd2); step(4'd3); step(4'd5); step(4'd1); step(4'd2); step(4'd0);
    check_eq("halt_in_loop", 32'(in_loop), 32'd0);
    check_eq("halt_invoc", 32'(invoc_count), 32'd2);
    check_eq("halt_no_iter_pulse", 32'(n_iter_p - pi), 32'd0);
    check_eq("halt_no_exit_pulse", 32'(n_exit_p - pe), 32'd0);

    // finish while idle halts without error
    do_reset();
    reset  = 1'b0;
    finish = 1'b1;
    step(4'd0);
    finish = 1'b0;
    check_eq("fin_idle_proto", 32'(protocol_err), 32'd0);
    step(4'd1); step(4'd2);
    check_eq("fin_idle_halted", 32'(in_loop), 32'd0);

`ifdef SEQ_LOOP_MON_MINMAX_EN
    // Min/max over invocations of 3, 1 and 6 iterations
    do_reset();
    check_eq("mm_rst_min", 32'(min_iters), 32'd255);
    check_eq("mm_rst_max", 32'(max_iters), 32'd0);
    reset = 1'b0;
    step(4'd1); step(4'd2); iterate(2); step(4'd3); step(4'd5);
    check_eq("mm_first_min", 32'(min_iters), 32'd3);
    check_eq("mm_first_max", 32'(max_iters), 32'd3);
    step(4'd1); step(4'd2); step(4'd3); step(4'd5);
    step(4'd1); step(4'd2); iterate(5); step(4'd3); step(4'd5);
    check_eq("mm_last_count", 32'(iter_count), 32'd6);
    check_eq("mm_min", 32'(min_iters), 32'd1);
    check_eq("mm_max", 32'(max_iters), 32'd6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_loop_monitor.md
Name: seq_loop_monitor

Overview:
Parametrised cycle-level monitor for one sequential loop in an HLS-generated FSM, used in RTL co-simulation benches. It watches `cur_state` against configurable pre/quit/iteration-end state sets. From these it tracks loop entry, iteration boundaries and exit. It reports per-invocation and total iteration counts, detects stalled loops, and flags `finish` arriving mid-loop. Successor to the fixed-set loop interface bundle: all state sets have parametrised size, and the block adds counting and error behaviour.

Parameters:
- FSM_WIDTH, 2, width of every FSM state value
- N_PRE, 4, number of pre-loop (entry source) states
- N_QUIT, 16, number of in-loop states that can exit the loop
- N_ITER_END, 4, number of in-loop states that end an iteration
- CNT_WIDTH, 32, width of all counters
- STALL_LIMIT, 1000000, cycles in-loop without an iteration boundary before `stall_err`

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- cur_state  in  FSM_WIDTH  DUT FSM current state
- pre_valid  in  N_PRE  per-entry enable for pre_states
- pre_states  in  N_PRE*FSM_WIDTH  packed pre-loop states; entry i at [i*FSM_WIDTH +: FSM_WIDTH]
- quit_valid  in  N_QUIT  per-entry enable for quit_states
- quit_states  in  N_QUIT*FSM_WIDTH  packed in-loop exit-source states
- iter_end_valid  in  N_ITER_END  per-entry enable
- iter_end_states  in  N_ITER_END*FSM_WIDTH  packed iteration-end states
- iter_start_state  in  FSM_WIDTH  first state of the loop body
- loop_quit_state  in  FSM_WIDTH  first state after loop exit
- one_state_loop  in  1  loop body is a single state
- one_state_block  in  1  body absorbed into one block; iterations are not counted
- finish  in  1  simulation finish request
- in_loop  out  1  monitor is in state LOOP
- iter_pulse  out  1  one-cycle pulse per completed iteration
- exit_pulse  out  1  one-cycle pulse on loop exit
- iter_count  out  CNT_WIDTH  iterations in the current or last invocation
- invoc_count  out  CNT_WIDTH  completed invocations since reset
- stall_err  out  1  sticky error flag
- protocol_err  out  1  sticky error flag

Behaviour:
- **Reset.** All outputs 0, FSM = IDLE, `prev_state` = 0. Reset mid-loop abandons the invocation with no `exit_pulse`.
- **Registered history.** `prev_state` <= `cur_state` every cycle.
- **Set matching.** match(set) = OR over i of (valid[i] && entry[i] == x). All set inputs are treated as static during simulation.
- **Transition events.** Evaluated combinationally, registered into outputs with 1-cycle latency.
  - entry = `prev_state` in PRE && `cur_state` == `iter_start_state`
  - iter = `prev_state` in ITER_END && `cur_state` == `iter_start_state`
  - When `one_state_loop` = 1: iter = (`prev_state` == `iter_start_state` && `cur_state` == `iter_start_state`)
  - exit = `prev_state` in QUIT && `cur_state` == `loop_quit_state`
- **FSM states:** IDLE, LOOP, HALT.
  - IDLE -> LOOP on entry. Clear `iter_count`; clear the stall counter.
  - LOOP -> LOOP on iter. Pulse `iter_pulse`; `iter_count`++ unless `one_state_block`; clear the stall counter.
  - LOOP -> IDLE on exit. Pulse `exit_pulse`; `invoc_count`++. The final pass through the body counts as an iteration: `iter_count`++ unless `one_state_block`.
  - exit and iter in the same cycle: exit wins; only one increment.
  - entry while in LOOP is ignored; set `protocol_err`.
  - exit while in IDLE is ignored; no error.
  - Any state + `finish`: HALT. If the FSM was in LOOP, set `protocol_err`. HALT is left only by reset.
- **Stall counter.** Increments each cycle in LOOP. When it equals STALL_LIMIT, set `stall_err` (sticky). The counter saturates; it does not wrap.
- **Counter saturation.** `iter_count` and `invoc_count` saturate at all-ones; they do not wrap.
- **`in_loop`** = (FSM == LOOP), registered.

Optional Feature:
- Macro: `SEQ_LOOP_MON_MINMAX_EN`.
- When defined, the block adds outputs `min_iters` and `max_iters` (CNT_WIDTH each). Both update on each exit using the final iteration count.
  - `min_iters` resets to all-ones; `max_iters` resets to 0.
  - Both are untouched when `one_state_block` = 1.
- When undefined, these ports and registers are absent.

Decomposition:
- Package `seq_loop_mon_pkg` holds:
  - the FSM state typedef enum {IDLE, LOOP, HALT}
  - the saturating-increment function
  - default STALL_LIMIT constant
- Sub-module `seq_state_set_match`, parametrised by N and FSM_WIDTH. Inputs: valid mask, packed set and query state. Output: 1-bit hit. Instantiated three times (PRE, QUIT, ITER_END).

Test Plan:
1. **Basic loop.** FSM_WIDTH = 4, pre = {1}, `iter_start_state` = 2, iter_end = {3}, quit = {3}, `loop_quit_state` = 5. Drive 1,2,3,2,3,2,3,5 -> `iter_pulse` x2, `exit_pulse` x1, `iter_count` = 3, `invoc_count` = 1.
2. **one_state_loop.** Set `one_state_loop` = 1. Drive 1,2,2,2,2,5 with quit = {2} -> `iter_count` = 4, `exit_pulse` one cycle after the 5.
3. **Stall.** STALL_LIMIT = 8. Enter the loop, then hold `cur_state` = 3 with no return to 2 -> `stall_err` rises on the 8th LOOP cycle and stays high after a later exit.
4. **finish mid-loop.** Assert `finish` while `in_loop` = 1 -> `protocol_err` = 1, FSM = HALT. Subsequent state traffic -> no pulses.
5. **Reset mid-loop and disabled entries.** Reset after 2 iterations -> all outputs 0, no `exit_pulse`. Set `quit_valid[0]` = 0 -> 3 -> 5 produces no exit.
6. **MINMAX (`SEQ_LOOP_MON_MINMAX_EN` defined).** Run invocations of 3, 1 and 6 iterations -> `min_iters` = 1, `max_iters` = 6.
